// File: rtl/simon_pkg.sv
// Shared constants, z-sequence tables and FSM encoding for the SIMON 64-bit key schedule.
package simon_pkg;

  localparam int          SIMON_N = 32;
  localparam logic [31:0] SIMON_C = 32'hFFFFFFFC;

  // Literals below are written leftmost-element-first; reversal puts element i at bit i.
  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    r = '0;
    for (int i = 0; i < 62; i++) begin
      r[i] = v[61-i];
    end
    return r;
  endfunction

  localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);

  function automatic int t_of_m(input int m);
    return (m == 4) ? 44 : 42;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/simon_key_step.sv
// One combinational SIMON key-expansion step: window w[0..M-1] and round index to the next key word.
module simon_key_step
  import simon_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int M = 4
) (
  input  logic [M-1:0][N-1:0] w,
  input  logic [5:0]          idx,
  output logic [N-1:0]        knew
);

  localparam logic [61:0] Z = (M == 4) ? Z3 : Z2;

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  logic [N-1:0] rot3;
  logic [N-1:0] tmp_a;
  logic [N-1:0] tmp_b;
  logic [5:0]   z_pos;
  logic         unused_w;

  assign rot3 = ror(w[M-1], 3);

  generate
    if (M == 4) begin : g_m4
      assign tmp_a = rot3 ^ w[1];
    end else begin : g_m3
      assign tmp_a = rot3;
    end
  endgenerate

  assign tmp_b = tmp_a ^ ror(tmp_a, 1);

  // The z sequence has period 62, so indices 62/63 wrap to the start.
  assign z_pos = (idx >= 6'd62) ? (idx - 6'd62) : idx;

  assign knew = SIMON_C ^ {{(N-1){1'b0}}, Z[z_pos]} ^ w[0] ^ tmp_b;

  // Only some window words feed the step; the rest are intentionally ignored.
  assign unused_w = ^w;

endmodule

// File: rtl/simon_key_schedule.sv
// Iterative SIMON 64/(32*M) key schedule streaming round keys k0..k(T-1) over valid/ready.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int M = 4,
  parameter int T = t_of_m(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [N*M-1:0] key_in,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk,
  output logic [5:0]     rk_idx,
  output logic           rk_last
);

  generate
    if (!(M == 3 || M == 4)) begin : g_bad_m
      $error("simon_key_schedule: M must be 3 or 4");
    end
    if (N != 32) begin : g_bad_n
      $error("simon_key_schedule: only N = 32 is supported");
    end
  endgenerate

  localparam logic [5:0] LAST_IDX = 6'(T - 1);

  state_t              state_reg, state_next;
  logic [M-1:0][N-1:0] w_reg, w_next, w_shift;
  logic [5:0]          idx_reg, idx_next;
  logic                rk_last_reg, rk_last_next;
  logic [N-1:0]        knew;

  simon_key_step #(
    .N(N),
    .M(M)
  ) u_step (
    .w   (w_reg),
    .idx (idx_reg),
    .knew(knew)
  );

  // Window slides one word towards w[0]; the freshly expanded word enters at the top.
  for (genvar gi = 0; gi < M; gi++) begin : g_shift
    if (gi < M - 1) begin : g_mid
      assign w_shift[gi] = w_reg[gi+1];
    end else begin : g_top
      assign w_shift[gi] = knew;
    end
  end

  always_comb begin
    state_next   = state_reg;
    w_next       = w_reg;
    idx_next     = idx_reg;
    rk_last_next = rk_last_reg;
    key_ready    = 1'b0;
    rk_valid     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          w_next       = key_in;
          idx_next     = '0;
          rk_last_next = (LAST_IDX == 6'd0);
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (idx_reg == LAST_IDX) begin
            idx_next     = '0;
            rk_last_next = 1'b0;
            state_next   = ST_IDLE;
          end else begin
            w_next       = w_shift;
            idx_next     = idx_reg + 6'd1;
            rk_last_next = ((idx_reg + 6'd1) == LAST_IDX);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      w_reg       <= '0;
      idx_reg     <= '0;
      rk_last_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      w_reg       <= w_next;
      idx_reg     <= idx_next;
      rk_last_reg <= rk_last_next;
    end
  end

  assign rk      = (state_reg == ST_RUN) ? w_reg[0] : '0;
  assign rk_idx  = idx_reg;
  assign rk_last = rk_last_reg;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for the SIMON key schedule: M=4 and M=3 builds plus the combinational step.
module tb_simon_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         rk_ready = 1'b0;
  logic         use3 = 1'b0;
  logic [127:0] key4 = '0;
  logic [95:0]  key3 = '0;

  logic        kv4, kr4, rv4, rl4;
  logic        kv3, kr3, rv3, rl3;
  logic [31:0] rk4, rk3;
  logic [5:0]  ri4, ri3;

  assign kv4 = key_valid & ~use3;
  assign kv3 = key_valid & use3;

  simon_key_schedule #(.N(32), .M(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_valid(kv4), .key_ready(kr4), .key_in(key4),
    .rk_valid(rv4), .rk_ready(rk_ready), .rk(rk4), .rk_idx(ri4), .rk_last(rl4)
  );

  simon_key_schedule #(.N(32), .M(3)) u_dut3 (
    .clk(clk), .rst(rst), .key_valid(kv3), .key_ready(kr3), .key_in(key3),
    .rk_valid(rv3), .rk_ready(rk_ready), .rk(rk3), .rk_idx(ri3), .rk_last(rl3)
  );

  logic [127:0] step_w = '0;
  logic [5:0]   step_idx = '0;
  logic [31:0]  step_knew;

  simon_key_step #(.N(32), .M(4)) u_step (
    .w(step_w), .idx(step_idx), .knew(step_knew)
  );

  logic        o_kr, o_valid, o_last;
  logic [31:0] o_rk;
  logic [5:0]  o_idx;
  assign o_kr    = use3 ? kr3 : kr4;
  assign o_valid = use3 ? rv3 : rv4;
  assign o_last  = use3 ? rl3 : rl4;
  assign o_rk    = use3 ? rk3 : rk4;
  assign o_idx   = use3 ? ri3 : ri4;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] K4   = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] K4B  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] K3   = 128'h00000000_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT4  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT4  = 64'h44c8fc20_b9dfa07a;
  localparam logic [63:0]  PT3  = 64'h6f722067_6e696c63;
  localparam logic [63:0]  CT3  = 64'h5ca2e27f_111a8fc8;

  logic [61:0] z2_tb = 62'b10101111011100000011010010011000101000010001111110010110110011;
  logic [61:0] z3_tb = 62'b11011011101011000110010111100000010010001010011100110100001111;
  logic [31:0] hand4 [0:4] = '{32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 32'h70a011c3};
  logic [31:0] mk [0:63];

  function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction

  // Published recurrence: k[i] = ~k[i-m] ^ 3 ^ z[i-m] ^ (tmp ^ ror(tmp,1)).
  function automatic void model_expand(input int m, input logic [127:0] key);
    logic [31:0] tmp;
    logic        zb;
    for (int i = 0; i < m; i++) mk[i] = key[32*i +: 32];
    for (int i = m; i < 64; i++) begin
      tmp = ror32(mk[i-1], 3);
      if (m == 4) tmp = tmp ^ mk[i-3];
      tmp = tmp ^ ror32(tmp, 1);
      zb  = (m == 4) ? z3_tb[61 - ((i - m) % 62)] : z2_tb[61 - ((i - m) % 62)];
      mk[i] = ~mk[i-m] ^ tmp ^ {31'b0, zb} ^ 32'd3;
    end
  endfunction

  function automatic logic [63:0] enc_round(input logic [63:0] x, input logic [31:0] k);
    logic [31:0] l, r;
    l = x[63:32];
    r = x[31:0];
    return {r ^ ((rol32(l, 1) & rol32(l, 8)) ^ rol32(l, 2)) ^ k, l};
  endfunction

  task automatic rst_pulse();
    rst = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Loads a key at full rate and encrypts pt with the streamed round keys.
  task automatic stream_all(input int m, input logic [127:0] key, input logic [63:0] pt,
                            output logic [63:0] ct);
    int          t;
    logic [63:0] x;
    t = (m == 4) ? 44 : 42;
    x = pt;
    use3 = (m == 3);
    model_expand(m, key);
    key4 = key;
    key3 = key[95:0];
    check("key_ready_idle", o_kr, 1);
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("first_valid_latency", o_valid, 1);
    for (int i = 0; i < t; i++) begin
      check("rk_valid", o_valid, 1);
      check("rk_idx", o_idx, i);
      check("rk_model", o_rk, mk[i]);
      check("rk_last", o_last, (i == t - 1));
      check("key_ready_run", o_kr, 0);
      if (m == 4 && i < 5) check("rk_hand", o_rk, hand4[i]);
      x = enc_round(x, o_rk);
      @(negedge clk);
    end
    check("valid_drop", o_valid, 0);
    check("key_ready_back", o_kr, 1);
    ct = x;
    $display("stream m=%0d key=%h pt=%h ct=%h", m, key, pt, x);
  endtask

  initial begin
    logic [63:0] ct;
    int          cnt, stall;
    logic        prev_valid, prev_hs;
    logic [31:0] prev_rk;
    logic [5:0]  prev_idx;

    // Combinational step: z indexing, wrap and one real expansion.
    step_w = K4; step_idx = 6'd0; #1;
    check("step_k4", step_knew, 32'h70a011c3);
    step_w = '0; step_idx = 6'd0; #1;
    check("step_z0", step_knew, 32'hFFFFFFFD);
    step_idx = 6'd5; #1;
    check("step_z5", step_knew, 32'hFFFFFFFC);
    step_idx = 6'd63; #1;
    check("step_zwrap", step_knew, 32'hFFFFFFFD);
    $display("step checks done");

    rst_pulse();
    use3 = 1'b0;
    check("rst_key_ready", o_kr, 1);
    check("rst_rk_valid", o_valid, 0);
    check("rst_rk", o_rk, 0);
    check("rst_rk_idx", o_idx, 0);
    check("rst_rk_last", o_last, 0);
    use3 = 1'b1;
    check("rst3_key_ready", o_kr, 1);
    check("rst3_rk_valid", o_valid, 0);

    // Full-rate M=4 stream, then back-to-back reload at minimum period.
    stream_all(4, K4, PT4, ct);
    check("ct_m4", ct, CT4);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("reload_valid", o_valid, 1);
    check("reload_idx", o_idx, 0);
    check("reload_rk", o_rk, mk[0]);
    rst_pulse();

    // Random backpressure with long stalls and key_valid noise during RUN.
    use3 = 1'b0;
    model_expand(4, K4);
    key4 = K4;
    key_valid = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    key4 = K4B;
    cnt = 0; stall = 0; prev_valid = 1'b0; prev_hs = 1'b1; prev_rk = '0; prev_idx = '0;
    for (int cyc = 0; cyc < 3000 && cnt < 44; cyc++) begin
      if (prev_valid && !prev_hs) begin
        check("stall_rk_hold", o_rk, prev_rk);
        check("stall_idx_hold", o_idx, prev_idx);
        check("stall_valid_hold", o_valid, 1);
      end
      check("rand_valid", o_valid, 1);
      check("rand_idx", o_idx, cnt);
      check("rand_rk", o_rk, mk[cnt]);
      check("rand_key_ready", o_kr, 0);
      key_valid = ($urandom_range(0, 3) == 0);
      if (cyc == 3) begin
        stall = 20; rk_ready = 1'b0;
      end else if (stall > 0) begin
        stall--; rk_ready = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        stall = $urandom_range(1, 19); rk_ready = 1'b0;
      end else begin
        rk_ready = $urandom_range(0, 1);
      end
      prev_valid = o_valid;
      prev_rk    = o_rk;
      prev_idx   = o_idx;
      prev_hs    = o_valid && rk_ready;
      if (prev_hs) cnt++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("rand_handshakes", cnt, 44);
    check("rand_done_valid", o_valid, 0);
    check("rand_done_ready", o_kr, 1);
    $display("random backpressure: handshakes=%0d", cnt);

    // Reset after the idx-17 handshake abandons the stream.
    rst_pulse();
    model_expand(4, K4);
    key4 = K4;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_reset_idx", o_idx, 17);
    check("pre_reset_rk", o_rk, mk[17]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", o_valid, 0);
    check("midrst_idx", o_idx, 0);
    check("midrst_key_ready", o_kr, 1);
    check("midrst_last", o_last, 0);
    model_expand(4, K4B);
    key4 = K4B;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("restart_idx", o_idx, 0);
    check("restart_rk", o_rk, mk[0]);
    @(negedge clk);
    check("restart_rk1", o_rk, mk[1]);
    $display("mid-stream reset and restart done");

    // Reset coincident with a key handshake: reset wins.
    rst_pulse();
    rst = 1'b1;
    key_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    check("rstwin_valid", o_valid, 0);
    check("rstwin_key_ready", o_kr, 1);
    @(negedge clk);
    check("rstwin_valid_later", o_valid, 0);
    $display("reset-vs-handshake done");

    // M=3 build.
    rst_pulse();
    stream_all(3, K3, PT3, ct);
    check("ct_m3", ct, CT3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
